button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Parametrised, multi-channel front end for raw push-button inputs. It replaces the single-flop synchronizer used in the game datapath.
- Each channel has three stages in order:
  - an N-stage synchronizer;
  - a consecutive-cycle debounce filter;
  - a registered rise/fall edge detector.
- Sits between board pins and game control logic (tug-of-war FSM, score counters). Downstream logic consumes only the one-cycle press/release pulses or the clean level.

Parameters:
- CHANNELS, 2: number of independent button channels (>=1).
- SYNC_STAGES, 2: flops in each synchronizer chain (>=1).
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized input must disagree with the debounced level before the level changes (>=1).

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- push, input, CHANNELS: raw asynchronous button inputs; bit i is channel i.
- en, input, CHANNELS: per-channel pulse enable. 0 masks rise/fall for that channel; level still tracks.
- level, output, CHANNELS: debounced, synchronized button level.
- rise, output, CHANNELS: one-cycle pulse when level goes 0->1 (press).
- fall, output, CHANNELS: one-cycle pulse when level goes 1->0 (release).
- any_rise, output, 1: registered OR of all rise bits.

Behaviour:
- Reset:
  - rst sampled high on an edge clears every sync flop, debounce counter, level, rise, fall and any_rise to 0.
  - rst overrides all other activity, including mid-count, and is effective on the same edge.
  - All outputs read 0 in the cycle following any reset edge.
- Synchronizer:
  - Per channel, a shift chain of SYNC_STAGES flops; s_i = last stage.
  - Behaviour is identical for every channel; channels never interact except through any_rise.
- Debounce, per channel, with counter cnt of width clog2(DEBOUNCE_CYCLES+1):
  - s_i == level_i: cnt <= 0.
  - s_i != level_i and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s_i != level_i and cnt == DEBOUNCE_CYCLES-1: level_i <= s_i, cnt <= 0.
  - The counter never wraps; it clears on any agreeing cycle.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s_i produces no level change and no pulse.
- Latency:
  - push_i stable from before edge E1 gives level_i updated on edge E(SYNC_STAGES+DEBOUNCE_CYCLES).
  - Defaults: 6 edges.
- Edge pulses:
  - On the edge where level_i changes 0->1, rise_i <= en_i. On the edge where level_i changes 1->0, fall_i <= en_i.
  - On every other edge, rise_i and fall_i <= 0.
  - Pulses are exactly one cycle and aligned with the new level value.
  - rise and fall are never simultaneously high on one channel.
  - en is sampled on the toggle edge only. A masked edge is lost, not deferred.
- any_rise:
  - any_rise <= OR over i of (next rise_i), so it asserts in the same cycle as rise.
  - Simultaneous presses on several channels give one any_rise cycle.
- Button held through reset:
  - After rst drops with push high, level rises after the full latency.
  - A rise pulse is produced if en is high.

Test Plan (CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
1. rst=1 for 3 edges with push=2'b11, en=2'b11 -> level, rise, fall, any_rise = 0 throughout and in the cycle after the last reset edge.
2. push[0] 0->1 before edge 1, held; en=2'b11 -> level[0]=1 after edge 6; rise[0]=1 and any_rise=1 only between edges 6 and 7; level[1], rise[1] stay 0.
3. From level[0]=1, push[0] low for 3 cycles then high -> level[0] stays 1, no fall. Then push[0] held low -> fall[0] single cycle after 6th edge, level[0]=0.
4. push=2'b11 together, en=2'b01 -> level=2'b11 on the same edge; rise=2'b01; any_rise one cycle only.
5. push[1] high, assert rst after edge 4 (cnt=2), release rst, keep push high -> level[1]=1 only 6 edges after rst release, with one rise[1] pulse.
6. Parameter sweep SYNC_STAGES=1, DEBOUNCE_CYCLES=1 -> level follows push 2 edges later; a 1-cycle push glitch produces a 1-cycle level pulse plus rise then fall.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Bundles the button pins and the conditioned level/pulse outputs.
// The bench drives through master; the conditioner sits on slave.
interface button_conditioner_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_rise;

    modport master (
        output push,
        output en,
        input  level,
        input  rise,
        input  fall,
        input  any_rise
    );

    modport slave (
        input  push,
        input  en,
        output level,
        output rise,
        output fall,
        output any_rise
    );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchronizer chain, consecutive-cycle
// debounce filter and registered rise/fall pulses gated by a per-channel enable.
module button_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);
    localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CNT_W-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]    level_q, level_d;
    logic [CHANNELS-1:0]    rise_q, rise_d;
    logic [CHANNELS-1:0]    fall_q, fall_d;
    logic                   any_rise_q, any_rise_d;
    logic [CHANNELS-1:0]    s;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // Bit 0 takes the raw pin; the top bit is the synchronized sample.
            sync_d[i]    = sync_q[i] << 1;
            sync_d[i][0] = bus.push[i];
            s[i]         = sync_q[i][SYNC_STAGES-1];

            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;

            // Counter only runs while the sample disagrees; any agreeing cycle clears it.
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    level_d[i] = s[i];
                    rise_d[i]  = s[i] & bus.en[i];
                    fall_d[i]  = ~s[i] & bus.en[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        any_rise_d = |rise_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_rise_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_rise_q <= any_rise_d;
        end
    end

    assign bus.level    = level_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.any_rise = any_rise_q;
endmodule
